// File: rtl/read_counter_ctl.sv
// read_counter_ctl: steps a 16-bit read counter from synchronised ternary error triggers and reports each step as a +/- pulse over a req/ack handshake
// Ports: clk, rst (sync, active-high); _TLF1H/_TLF1L/_TLF2H/_TLF2L async active-low triggers; zero clears counter state;
//        cdu_ack acknowledges the current pulse; angle counter value; _D15.._D21 active-low ladder drives (~angle[6:0]);
//        cdu_up/cdu_dn pulse requests; pend_ovf sticky pending-overflow flag.
module read_counter_ctl #(
    parameter int SLOW_DIV = 16,
    parameter int FAST_DIV = 2,
    parameter int PEND_MAX = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        _TLF1H,
    input  logic        _TLF1L,
    input  logic        _TLF2H,
    input  logic        _TLF2L,
    input  logic        zero,
    input  logic        cdu_ack,
    output logic [15:0] angle,
    output logic        _D15,
    output logic        _D16,
    output logic        _D17,
    output logic        _D18,
    output logic        _D19,
    output logic        _D20,
    output logic        _D21,
    output logic        cdu_up,
    output logic        cdu_dn,
    output logic        pend_ovf
);
    typedef enum logic [2:0] {M_IDLE, M_FUP, M_FDN, M_CUP, M_CDN} mode_e;
    typedef enum logic [1:0] {S_IDLE, S_REQ_UP, S_REQ_DN, S_GAP} hs_e;
    localparam logic [7:0] SLOW_M1 = 8'(SLOW_DIV - 1);
    localparam logic [7:0] FAST_M1 = 8'(FAST_DIV - 1);
    localparam logic signed [8:0] PMAX = 9'(PEND_MAX);
    logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;
    mode_e mode, mode_prev_q, mode_prev_d;
    hs_e state_q, state_d;
    logic [7:0] timer_q, timer_d, timer_eff, div_m1;
    logic signed [8:0] pend_q, pend_d, pend_post, pend_step;
    logic [15:0] angle_q, angle_d;
    logic ovf_q, ovf_d, up_q, up_d, dn_q, dn_d;
    logic f1h, f1l, f2h, f2l, active, dir_up, step, acked, room, take;
    assign {f1h, f1l, f2h, f2l} = ~sync2_q;
    assign angle = angle_q;
    assign {_D15, _D16, _D17, _D18, _D19, _D20, _D21} = ~angle_q[6:0];
    assign cdu_up = up_q;
    assign cdu_dn = dn_q;
    assign pend_ovf = ovf_q;
    always_comb begin
        sync1_d = {_TLF1H, _TLF1L, _TLF2H, _TLF2L};
        sync2_d = sync1_q;
        mode = (f2h && !f2l) ? M_CUP :
               (f2l && !f2h) ? M_CDN :
               (f1h && !f1l) ? M_FUP :
               (f1l && !f1h) ? M_FDN : M_IDLE;
        mode_prev_d = mode;
        div_m1 = (mode == M_CUP || mode == M_CDN) ? FAST_M1 : SLOW_M1;
        active = mode != M_IDLE;
        dir_up = mode == M_FUP || mode == M_CUP;
        // a mode change takes effect as a reload in the same clock, so the first step lands DIV clocks after the new mode appears
        timer_eff = (mode != mode_prev_q) ? div_m1 : timer_q;
        step = active && timer_eff == 8'd0;
        timer_d = !active ? 8'd0 : step ? div_m1 : timer_eff - 8'd1;
        acked = cdu_ack && (state_q == S_REQ_UP || state_q == S_REQ_DN);
        pend_post = pend_q + (!acked ? 9'sd0 : state_q == S_REQ_UP ? -9'sd1 : 9'sd1);
        pend_step = pend_post + (dir_up ? 9'sd1 : -9'sd1);
        room = pend_step <= PMAX && pend_step >= -PMAX;
        take = step && room;
        pend_d = take ? pend_step : pend_post;
        angle_d = !take ? angle_q : dir_up ? angle_q + 16'd1 : angle_q - 16'd1;
        ovf_d = ovf_q || (step && !room);
        state_d = state_q;
        // GAP decides the next request directly so back-to-back pulses cost two clocks
        if (state_q == S_IDLE || state_q == S_GAP)
            state_d = pend_q > 9'sd0 ? S_REQ_UP : pend_q < 9'sd0 ? S_REQ_DN : S_IDLE;
        else if (acked)
            state_d = S_GAP;
        if (zero) begin
            angle_d = 16'd0;
            pend_d = 9'sd0;
            state_d = S_IDLE;
            timer_d = 8'd0;
            ovf_d = 1'b0;
            mode_prev_d = M_IDLE;
        end
        up_d = state_d == S_REQ_UP;
        dn_d = state_d == S_REQ_DN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            mode_prev_q <= M_IDLE;
            timer_q <= 8'd0;
            pend_q <= 9'sd0;
            angle_q <= 16'd0;
            state_q <= S_IDLE;
            ovf_q <= 1'b0;
            up_q <= 1'b0;
            dn_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            mode_prev_q <= mode_prev_d;
            timer_q <= timer_d;
            pend_q <= pend_d;
            angle_q <= angle_d;
            state_q <= state_d;
            ovf_q <= ovf_d;
            up_q <= up_d;
            dn_q <= dn_d;
        end
    end
endmodule
